// File: rtl/boot_sequencer_if.sv
// Boot sequencer bus interface.
// Groups every non-clock/reset signal of the boot sequencer:
//   CPU fetch port : cpu_rst, cpu_stall, cpu_iaddr, cpu_idata
//   start-up ROM   : rom_addr, rom_data, rom_done
//   instr RAM      : ram_addr, ram_rdata, ram_we, ram_wdata
//   loader stream  : ld_valid, ld_data, ld_last, ld_ready
//   status         : state, load_count
// slave  : seen by the sequencer itself
// master : seen by the surrounding system (CPU, ROM, RAM, loader)
interface boot_sequencer_if;
  logic        cpu_rst;
  logic        cpu_stall;
  logic [31:0] cpu_iaddr;
  logic [31:0] cpu_idata;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        rom_done;
  logic [31:0] ram_addr;
  logic [31:0] ram_rdata;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        ld_ready;
  logic [1:0]  state;
  logic [31:0] load_count;

  modport slave (
    input  cpu_iaddr, rom_data, rom_done, ram_rdata, ld_valid, ld_data, ld_last,
    output cpu_rst, cpu_stall, cpu_idata, rom_addr, ram_addr, ram_we, ram_wdata,
           ld_ready, state, load_count
  );

  modport master (
    output cpu_iaddr, rom_data, rom_done, ram_rdata, ld_valid, ld_data, ld_last,
    input  cpu_rst, cpu_stall, cpu_idata, rom_addr, ram_addr, ram_we, ram_wdata,
           ld_ready, state, load_count
  );
endinterface

// File: rtl/boot_sequencer.sv
// Boot sequencer: owns instruction-fetch sequencing from power-on to normal run.
//   HOLD     : CPU held in reset for RESET_HOLD cycles.
//   ROM_EXEC : fetches served by the start-up ROM until it reports done.
//   LOAD     : CPU stalled while the loader streams words into instruction RAM.
//   RUN      : fetches served by instruction RAM until the next reset.
// Ports:
//   i_clk  : system clock, all logic on posedge
//   i_rst  : synchronous active-high reset
//   io_bus : boot_sequencer_if.slave (CPU, ROM, RAM, loader and status signals)
module boot_sequencer #(
  parameter int unsigned RESET_HOLD     = 16,
  parameter int unsigned LOAD_WORDS_MAX = 1024,
  parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
  input  logic             i_clk,
  input  logic             i_rst,
  boot_sequencer_if.slave  io_bus
);

  localparam logic [31:0] HoldLast = 32'(RESET_HOLD - 1);
  localparam logic [31:0] LoadLast = 32'(LOAD_WORDS_MAX - 1);

  typedef enum logic [1:0] {
    StHold    = 2'd0,
    StRomExec = 2'd1,
    StLoad    = 2'd2,
    StRun     = 2'd3
  } state_e;

  // Source of the word returned to the CPU this cycle, chosen last cycle so it
  // lines up with the 1-cycle latency of ROM and RAM.
  typedef enum logic [1:0] {
    SrcNone = 2'd0,
    SrcRom  = 2'd1,
    SrcRam  = 2'd2
  } src_e;

  state_e      r_state, w_state_d;
  src_e        r_src, w_src_d;
  logic [31:0] r_hold_cnt, w_hold_cnt_d;
  logic [31:0] r_load_count, w_load_count_d;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StHold;
      r_src        <= SrcNone;
      r_hold_cnt   <= '0;
      r_load_count <= '0;
    end else begin
      r_state      <= w_state_d;
      r_src        <= w_src_d;
      r_hold_cnt   <= w_hold_cnt_d;
      r_load_count <= w_load_count_d;
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_src_d          = r_src;
    w_hold_cnt_d     = r_hold_cnt;
    w_load_count_d   = r_load_count;
    io_bus.cpu_rst   = 1'b0;
    io_bus.cpu_stall = 1'b0;
    io_bus.rom_addr  = '0;
    io_bus.ram_addr  = '0;
    io_bus.ram_we    = 1'b0;
    io_bus.ram_wdata = '0;
    io_bus.ld_ready  = 1'b0;

    unique case (r_state)
      StHold: begin
        io_bus.cpu_rst = 1'b1;
        w_hold_cnt_d   = r_hold_cnt + 32'd1;
        if (r_hold_cnt == HoldLast) begin
          w_state_d = StRomExec;
        end
      end

      StRomExec: begin
        io_bus.rom_addr = io_bus.cpu_iaddr;
        if (io_bus.rom_done) begin
          // The jump in rom_data this cycle is still delivered; NOPs follow.
          w_state_d = StLoad;
          w_src_d   = SrcNone;
        end else begin
          w_src_d = SrcRom;
        end
      end

      StLoad: begin
        io_bus.cpu_stall = 1'b1;
        io_bus.ld_ready  = 1'b1;
        io_bus.ram_addr  = r_load_count << 2;
        io_bus.ram_wdata = io_bus.ld_data;
        if (io_bus.ld_valid) begin
          io_bus.ram_we  = 1'b1;
          w_load_count_d = r_load_count + 32'd1;
          if (io_bus.ld_last || (r_load_count == LoadLast)) begin
            w_state_d = StRun;
          end
        end
      end

      StRun: begin
        io_bus.ram_addr = io_bus.cpu_iaddr;
        w_src_d         = SrcRam;
      end
    endcase
  end

  always_comb begin
    case (r_src)
      SrcRom:  io_bus.cpu_idata = io_bus.rom_data;
      SrcRam:  io_bus.cpu_idata = io_bus.ram_rdata;
      default: io_bus.cpu_idata = NOP_WORD;
    endcase
  end

  assign io_bus.state      = r_state;
  assign io_bus.load_count = r_load_count;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed self-checking bench for boot_sequencer.
// u_dut_a uses RESET_HOLD=16 / LOAD_WORDS_MAX=1024; u_dut_b uses RESET_HOLD=2 /
// LOAD_WORDS_MAX=4 to reach the word-limit exit quickly.
module tb_boot_sequencer;
  localparam logic [31:0] Nop = 32'h00000013;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  boot_sequencer_if bus_a ();
  boot_sequencer_if bus_b ();

  boot_sequencer #(
    .RESET_HOLD     (16),
    .LOAD_WORDS_MAX (1024),
    .NOP_WORD       (Nop)
  ) u_dut_a (
    .i_clk  (clk),
    .i_rst  (rst_a),
    .io_bus (bus_a)
  );

  boot_sequencer #(
    .RESET_HOLD     (2),
    .LOAD_WORDS_MAX (4),
    .NOP_WORD       (Nop)
  ) u_dut_b (
    .i_clk  (clk),
    .i_rst  (rst_b),
    .io_bus (bus_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_inputs();
    rst_a           = 1'b1;
    rst_b           = 1'b1;
    bus_a.cpu_iaddr = '0;
    bus_a.rom_data  = 32'hDEADBEEF;
    bus_a.rom_done  = 1'b0;
    bus_a.ram_rdata = 32'hCAFEF00D;
    bus_a.ld_valid  = 1'b0;
    bus_a.ld_data   = '0;
    bus_a.ld_last   = 1'b0;
    bus_b.cpu_iaddr = '0;
    bus_b.rom_data  = 32'hDEADBEEF;
    bus_b.rom_done  = 1'b0;
    bus_b.ram_rdata = 32'hCAFEF00D;
    bus_b.ld_valid  = 1'b0;
    bus_b.ld_data   = '0;
    bus_b.ld_last   = 1'b0;
  endtask

  // Reset values, then cpu_rst high for exactly 16 cycles after rst falls.
  task automatic test_reset();
    bus_a.ld_valid = 1'b1;  // a loader word during reset must be ignored
    step();
    step();
    step();
    checks++;
    if (bus_a.state !== 2'd0 || bus_a.cpu_rst !== 1'b1 || bus_a.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl state=%0d cpu_rst=%b stall=%b want 0/1/0",
               bus_a.state, bus_a.cpu_rst, bus_a.cpu_stall);
    end
    checks++;
    if (bus_a.ram_we !== 1'b0 || bus_a.ld_ready !== 1'b0 || bus_a.load_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_load we=%b ready=%b count=%0d want 0/0/0",
               bus_a.ram_we, bus_a.ld_ready, bus_a.load_count);
    end
    checks++;
    if (bus_a.cpu_idata !== Nop || bus_a.rom_addr !== 32'd0 || bus_a.ram_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_data idata=%h rom_addr=%h ram_addr=%h want %h/0/0",
               bus_a.cpu_idata, bus_a.rom_addr, bus_a.ram_addr, Nop);
    end
    bus_a.ld_valid = 1'b0;
    rst_a = 1'b0;
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (bus_a.cpu_rst !== 1'b1 || bus_a.state !== 2'd0) begin
        errors++;
        $display("FAIL hold_cycle%0d cpu_rst=%b state=%0d want 1/0",
                 k, bus_a.cpu_rst, bus_a.state);
      end
      step();
    end
    checks++;
    if (bus_a.cpu_rst !== 1'b0 || bus_a.state !== 2'd1 || bus_a.cpu_idata !== Nop) begin
      errors++;
      $display("FAIL hold_exit cpu_rst=%b state=%0d idata=%h want 0/1/%h",
               bus_a.cpu_rst, bus_a.state, bus_a.cpu_idata, Nop);
    end
  endtask

  // ROM fetches: rom_addr follows cpu_iaddr, data returns one cycle later.
  task automatic test_rom_exec();
    bus_a.cpu_iaddr = 32'h0;
    bus_a.ld_valid  = 1'b1;
    bus_a.ld_data   = 32'h12345678;
    #1;
    checks++;
    if (bus_a.rom_addr !== 32'h0 || bus_a.ld_ready !== 1'b0 || bus_a.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rom_first rom_addr=%h ready=%b we=%b want 0/0/0",
               bus_a.rom_addr, bus_a.ld_ready, bus_a.ram_we);
    end
    step();
    bus_a.rom_data  = 32'h40000113;
    bus_a.cpu_iaddr = 32'h4;
    #1;
    checks++;
    if (bus_a.rom_addr !== 32'h4 || bus_a.cpu_idata !== 32'h40000113) begin
      errors++;
      $display("FAIL rom_word0 rom_addr=%h idata=%h want 4/40000113",
               bus_a.rom_addr, bus_a.cpu_idata);
    end
    step();
    bus_a.rom_data  = 32'h00000413;
    bus_a.cpu_iaddr = 32'h8;
    #1;
    checks++;
    if (bus_a.cpu_idata !== 32'h00000413 || bus_a.state !== 2'd1 || bus_a.cpu_stall !== 1'b0)
    begin
      errors++;
      $display("FAIL rom_word1 idata=%h state=%0d stall=%b want 00000413/1/0",
               bus_a.cpu_idata, bus_a.state, bus_a.cpu_stall);
    end
    bus_a.ld_valid = 1'b0;
  endtask

  // rom_done: jump still delivered, then LOAD with stall and ld_ready.
  task automatic test_rom_done();
    step();
    bus_a.rom_data  = 32'h000000e7;
    bus_a.cpu_iaddr = 32'hC;
    bus_a.rom_done  = 1'b1;
    #1;
    checks++;
    if (bus_a.cpu_idata !== 32'h000000e7 || bus_a.state !== 2'd1) begin
      errors++;
      $display("FAIL done_jump idata=%h state=%0d want 000000e7/1",
               bus_a.cpu_idata, bus_a.state);
    end
    step();
    checks++;
    if (bus_a.state !== 2'd2 || bus_a.cpu_stall !== 1'b1 || bus_a.ld_ready !== 1'b1 ||
        bus_a.cpu_idata !== Nop) begin
      errors++;
      $display("FAIL done_load state=%0d stall=%b ready=%b idata=%h want 2/1/1/%h",
               bus_a.state, bus_a.cpu_stall, bus_a.ld_ready, bus_a.cpu_idata, Nop);
    end
  endtask

  // Three words with gaps; writes only on handshake cycles, ld_last ends LOAD.
  task automatic test_load();
    logic [6:0]  vld;
    logic [31:0] words [3];
    int          idx;
    vld      = 7'b1001010;  // bit i = ld_valid in cycle i
    words[0] = 32'hAAAA0001;
    words[1] = 32'hAAAA0002;
    words[2] = 32'hAAAA0003;
    idx      = 0;
    for (int i = 0; i < 7; i++) begin
      bus_a.ld_valid = vld[i];
      bus_a.ld_data  = vld[i] ? words[idx] : 32'h55555555;
      bus_a.ld_last  = (i == 6);
      #1;
      checks++;
      if (bus_a.ram_we !== vld[i]) begin
        errors++;
        $display("FAIL load_we cycle%0d got %b want %b", i, bus_a.ram_we, vld[i]);
      end
      if (vld[i]) begin
        checks++;
        if (bus_a.ram_addr !== 32'(idx * 4) || bus_a.ram_wdata !== words[idx]) begin
          errors++;
          $display("FAIL load_write cycle%0d addr=%h data=%h want %h/%h",
                   i, bus_a.ram_addr, bus_a.ram_wdata, 32'(idx * 4), words[idx]);
        end
        idx++;
      end
      step();
      checks++;
      if (bus_a.load_count !== 32'(idx)) begin
        errors++;
        $display("FAIL load_count cycle%0d got %0d want %0d", i, bus_a.load_count, idx);
      end
    end
    bus_a.ld_valid = 1'b0;
    bus_a.ld_last  = 1'b0;
    checks++;
    if (bus_a.state !== 2'd3 || bus_a.ld_ready !== 1'b0 || bus_a.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_exit state=%0d ready=%b stall=%b want 3/0/0",
               bus_a.state, bus_a.ld_ready, bus_a.cpu_stall);
    end
  endtask

  // RUN: first fetch is a NOP bubble, then RAM data; loader ignored.
  task automatic test_run();
    bus_a.cpu_iaddr = 32'h0;
    bus_a.ram_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if (bus_a.ram_addr !== 32'h0 || bus_a.cpu_idata !== Nop || bus_a.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL run_bubble addr=%h idata=%h we=%b want 0/%h/0",
               bus_a.ram_addr, bus_a.cpu_idata, bus_a.ram_we, Nop);
    end
    step();
    bus_a.ram_rdata = 32'hAAAA0001;
    bus_a.cpu_iaddr = 32'h4;
    bus_a.ld_valid  = 1'b1;
    #1;
    checks++;
    if (bus_a.cpu_idata !== 32'hAAAA0001 || bus_a.ram_addr !== 32'h4 ||
        bus_a.load_count !== 32'd3 || bus_a.state !== 2'd3) begin
      errors++;
      $display("FAIL run_fetch idata=%h addr=%h count=%0d state=%0d want AAAA0001/4/3/3",
               bus_a.cpu_idata, bus_a.ram_addr, bus_a.load_count, bus_a.state);
    end
    checks++;
    if (bus_a.ld_ready !== 1'b0 || bus_a.ram_we !== 1'b0) begin
      errors++;
      $display("FAIL run_loader ready=%b we=%b want 0/0", bus_a.ld_ready, bus_a.ram_we);
    end
    step();
    bus_a.ld_valid = 1'b0;
  endtask

  // Word limit of 4 ends LOAD without ld_last; a 5th word is refused.
  task automatic test_max_words();
    int n;
    rst_b = 1'b0;
    n = 0;
    while (bus_b.state !== 2'd1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (bus_b.state !== 2'd1) begin
      errors++;
      $display("FAIL max_reach_rom state=%0d want 1 within 20 cycles", bus_b.state);
    end
    bus_b.rom_done = 1'b1;
    step();
    checks++;
    if (bus_b.state !== 2'd2) begin
      errors++;
      $display("FAIL max_reach_load state=%0d want 2", bus_b.state);
    end
    for (int i = 0; i < 5; i++) begin
      bus_b.ld_valid = 1'b1;
      bus_b.ld_data  = 32'hBBBB0000 + 32'(i);
      bus_b.ld_last  = 1'b0;
      #1;
      checks++;
      if (i < 4) begin
        if (bus_b.ram_we !== 1'b1 || bus_b.ram_addr !== 32'(i * 4) || bus_b.ld_ready !== 1'b1)
        begin
          errors++;
          $display("FAIL max_write%0d we=%b addr=%h ready=%b want 1/%h/1",
                   i, bus_b.ram_we, bus_b.ram_addr, bus_b.ld_ready, 32'(i * 4));
        end
      end else if (bus_b.ram_we !== 1'b0 || bus_b.ld_ready !== 1'b0) begin
        errors++;
        $display("FAIL max_fifth we=%b ready=%b want 0/0", bus_b.ram_we, bus_b.ld_ready);
      end
      step();
    end
    bus_b.ld_valid = 1'b0;
    checks++;
    if (bus_b.state !== 2'd3 || bus_b.load_count !== 32'd4) begin
      errors++;
      $display("FAIL max_exit state=%0d count=%0d want 3/4", bus_b.state, bus_b.load_count);
    end
  endtask

  // Reset during LOAD aborts it; the following boot repeats from scratch.
  task automatic test_back_to_back();
    int n;
    for (int pass = 0; pass < 2; pass++) begin
      rst_a          = 1'b1;
      bus_a.rom_done = 1'b0;
      bus_a.ld_valid = 1'b0;
      step();
      rst_a = 1'b0;
      n = 0;
      while (bus_a.state !== 2'd1 && n < 40) begin
        step();
        n++;
      end
      checks++;
      if (n !== 16) begin
        errors++;
        $display("FAIL reboot%0d_hold cycles=%0d want 16", pass, n);
      end
      bus_a.rom_done = 1'b1;
      step();
      checks++;
      if (bus_a.state !== 2'd2 || bus_a.load_count !== 32'd0) begin
        errors++;
        $display("FAIL reboot%0d_load state=%0d count=%0d want 2/0",
                 pass, bus_a.state, bus_a.load_count);
      end
      if (pass == 0) begin
        bus_a.ld_valid = 1'b1;
        bus_a.ld_data  = 32'h77770000;
        bus_a.ld_last  = 1'b0;
        step();
        step();
        checks++;
        if (bus_a.load_count !== 32'd2) begin
          errors++;
          $display("FAIL abort_pre count=%0d want 2", bus_a.load_count);
        end
        rst_a = 1'b1;  // ld_valid stays high across the reset edge
        step();
        checks++;
        if (bus_a.state !== 2'd0 || bus_a.cpu_rst !== 1'b1 || bus_a.load_count !== 32'd0 ||
            bus_a.ram_we !== 1'b0 || bus_a.ld_ready !== 1'b0) begin
          errors++;
          $display("FAIL abort state=%0d cpu_rst=%b count=%0d we=%b ready=%b want 0/1/0/0/0",
                   bus_a.state, bus_a.cpu_rst, bus_a.load_count, bus_a.ram_we,
                   bus_a.ld_ready);
        end
      end else begin
        bus_a.ld_valid = 1'b1;
        bus_a.ld_data  = 32'h99990001;
        bus_a.ld_last  = 1'b1;
        #1;
        checks++;
        if (bus_a.ram_we !== 1'b1 || bus_a.ram_addr !== 32'h0 ||
            bus_a.ram_wdata !== 32'h99990001) begin
          errors++;
          $display("FAIL reboot_write we=%b addr=%h data=%h want 1/0/99990001",
                   bus_a.ram_we, bus_a.ram_addr, bus_a.ram_wdata);
        end
        step();
        bus_a.ld_valid = 1'b0;
        bus_a.ld_last  = 1'b0;
        checks++;
        if (bus_a.state !== 2'd3 || bus_a.load_count !== 32'd1) begin
          errors++;
          $display("FAIL reboot_run state=%0d count=%0d want 3/1",
                   bus_a.state, bus_a.load_count);
        end
      end
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_rom_exec();
    test_rom_done();
    test_load();
    test_run();
    test_max_words();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
